// File: rtl/prefetch_pkg.sv
// prefetch_pkg: shared fetch constants and the compressed-halfword test
package prefetch_pkg;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  localparam int OPC_W = 2;
  localparam logic [WORD_W-1:0] NOP = 32'h0000_0013;
  function automatic logic is_compressed(input logic [HALF_W-1:0] h);
    return h[OPC_W-1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: circular buffer with 0..2 entries pushed/popped per cycle; PAIR exposes two head entries
module prefetch_fifo #(
  parameter int EW = 16,
  parameter int N = 8,
  parameter bit PAIR = 1'b1,
  localparam int HW = PAIR ? 2 * EW : EW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [1:0]        push_n,
  input  logic [1:0]        pop_n,
  input  logic [HW-1:0]     din,
  output logic [HW-1:0]     head,
  output logic [$clog2(N):0] count,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(N);
  logic [EW-1:0] mem [N];
  logic [PW-1:0] wp, rp, wp1, rp1;
  assign wp1 = wp + PW'(1);
  assign rp1 = rp + PW'(1);
  assign full = count == (PW + 1)'(N);
  assign empty = count == '0;
  if (PAIR) begin : g_pair
    assign head = {mem[rp1], mem[rp]};
  end else begin : g_one
    assign head = mem[rp];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push_n != 2'd0) mem[wp] <= din[EW-1:0];
      if (push_n == 2'd2) mem[wp1] <= din[HW-1 -: EW];
      wp <= wp + PW'(push_n);
      rp <= rp + PW'(pop_n);
      count <= count + (PW + 1)'(push_n) - (PW + 1)'(pop_n);
    end
  end
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: fetch buffer between instruction bus and decode with PC redirect and bus flush
// PREFETCH_COMPRESSED_EN enables halfword realignment for compressed code; default is a word FIFO
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instruction_request,
  output logic [31:0] instruction_address,
  input  logic        instruction_response,
  input  logic [31:0] instruction_data,
  output logic        flush_bus,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        out_is_compressed
);
`ifdef PREFETCH_COMPRESSED_EN
  localparam int EW = HALF_W;
  localparam int EN = 2 * DEPTH;
  localparam int SLOT = 2;
  localparam bit PAIR = 1'b1;
`else
  localparam int EW = WORD_W;
  localparam int EN = DEPTH;
  localparam int SLOT = 1;
  localparam bit PAIR = 1'b0;
`endif
  localparam int CW = $clog2(EN) + 1;
  logic [WORD_W-1:0] din, head, pc_step, tgt_pc;
  logic [CW-1:0] count, count_next;
  logic [1:0] push_n, pop_n;
  logic full, empty, accept, fire;
  assign accept = instruction_request && instruction_response && !redirect_valid && !full;
  assign fire = out_valid && out_ready && !redirect_valid;
  assign count_next = count + CW'(push_n) - CW'(pop_n);
`ifdef PREFETCH_COMPRESSED_EN
  logic comp, skip_low;
  assign comp = is_compressed(head[HALF_W-1:0]);
  assign out_is_compressed = comp;
  assign out_valid = count >= CW'(2) || (!empty && comp);
  assign out_instruction = !out_valid ? NOP : comp ? {16'h0, head[HALF_W-1:0]} : head;
  // after a redirect into the upper half, only that half of the first word is kept
  assign din = skip_low ? {instruction_data[15:0], instruction_data[31:16]} : instruction_data;
  assign push_n = accept ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
  assign pop_n = fire ? (comp ? 2'd1 : 2'd2) : 2'd0;
  assign pc_step = comp ? 32'd2 : 32'd4;
  assign tgt_pc = redirect_target;
  always_ff @(posedge clk) begin
    if (!rst_n) skip_low <= 1'b0;
    else if (redirect_valid) skip_low <= redirect_target[1];
    else if (accept) skip_low <= 1'b0;
  end
`else
  logic unused_tgt;
  assign unused_tgt = ^redirect_target[1:0];
  assign out_is_compressed = 1'b0;
  assign out_valid = !empty;
  assign out_instruction = out_valid ? head : NOP;
  assign din = instruction_data;
  assign push_n = {1'b0, accept};
  assign pop_n = {1'b0, fire};
  assign pc_step = 32'd4;
  assign tgt_pc = {redirect_target[31:2], 2'b00};
`endif
  prefetch_fifo #(.EW(EW), .N(EN), .PAIR(PAIR)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(redirect_valid),
    .push_n(push_n),
    .pop_n(pop_n),
    .din(din),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instruction_request <= 1'b0;
      flush_bus <= 1'b0;
      instruction_address <= BOOT_ADDRESS;
      out_pc <= BOOT_ADDRESS;
    end else if (redirect_valid) begin
      flush_bus <= instruction_request && !instruction_response;
      instruction_request <= !(instruction_request && !instruction_response);
      instruction_address <= {redirect_target[31:2], 2'b00};
      out_pc <= tgt_pc;
    end else begin
      flush_bus <= 1'b0;
      // hold an outstanding request; otherwise request only if a full word will still fit
      instruction_request <= (instruction_request && !instruction_response) ||
                             count_next <= CW'(EN - SLOT);
      if (accept) instruction_address <= instruction_address + 32'd4;
      if (fire) out_pc <= out_pc + pc_step;
    end
  end
endmodule
